// File: rtl/decode_stage.sv
// Registered picoRISC decode stage: one opcode per cycle in, registered controls out one cycle later.
// Branches may park in BRWAIT until the branch switch resolves or the wait limit expires.
module decode_stage #(
    parameter int              OPW      = 6,
    parameter int              FLAGW    = 4,
    parameter int              ALUW     = 3,
    parameter int              WAIT_MAX = 255,
    parameter logic [ALUW-1:0] ALU_ADD  = 3'b010,
    parameter logic [ALUW-1:0] ALU_MUL  = 3'b011,
    parameter logic [ALUW-1:0] ALU_PASS = 3'b000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   opcode,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [FLAGW-1:0] flags,
    input  logic             ready,
    input  logic             br_cond,
    output logic             dec_valid,
    output logic             pc_incr,
    output logic             pc_absbranch,
    output logic             pc_relbranch,
    output logic [ALUW-1:0]  ALUfunc,
    output logic             imm,
    output logic             w,
    output logic             store,
    output logic             disp,
    output logic             illegal,
    output logic [7:0]       wait_cnt
);

    localparam logic [OPW-1:0] OP_NOP  = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_ADDF = OPW'(6'b000011);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_MULI = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_DISP = OPW'(6'b000110);
    localparam logic [OPW-1:0] OP_ST   = OPW'(6'b000111);
    localparam logic [OPW-1:0] OP_BREL = OPW'(6'b100000);
    localparam logic [OPW-1:0] OP_BABS = OPW'(6'b100001);

    localparam bit         TIMEOUT_EN = (WAIT_MAX != 0);
    localparam logic [7:0] WAIT_LAST  = 8'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BRWAIT = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [FLAGW-1:0] flags_q, flags_d;
    logic [ALUW-1:0]  alu_func_q, alu_func_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic instr_ready_q, instr_ready_d;
    logic dec_valid_q, dec_valid_d;
    logic pc_incr_q, pc_incr_d;
    logic pc_abs_q, pc_abs_d;
    logic pc_rel_q, pc_rel_d;
    logic imm_q, imm_d;
    logic w_q, w_d;
    logic store_q, store_d;
    logic disp_q, disp_d;
    logic illegal_q, illegal_d;
    logic br_abs_q, br_abs_d;
    logic accept, br_go;

    assign accept = instr_valid & instr_ready_q;
    assign br_go  = (ready != br_cond);

    always_comb begin
        state_d       = state_q;
        flags_d       = flags_q;
        br_abs_d      = br_abs_q;
        wait_cnt_d    = 8'd0;
        alu_func_d    = ALU_PASS;
        dec_valid_d   = 1'b0;
        pc_incr_d     = 1'b0;
        pc_abs_d      = 1'b0;
        pc_rel_d      = 1'b0;
        imm_d         = 1'b0;
        w_d           = 1'b0;
        store_d       = 1'b0;
        disp_d        = 1'b0;
        illegal_d     = 1'b0;

        case (state_q)
            RUN: begin
                if (accept) begin
                    dec_valid_d = 1'b1;
                    pc_incr_d   = 1'b1;
                    case (opcode)
                        OP_NOP: ;
                        OP_ADD: begin
                            alu_func_d = ALU_ADD;
                            w_d        = 1'b1;
                        end
                        OP_ADDI: begin
                            alu_func_d = ALU_ADD;
                            w_d        = 1'b1;
                            imm_d      = 1'b1;
                        end
                        OP_ADDF: begin
                            alu_func_d = ALU_ADD;
                            w_d        = 1'b1;
                            flags_d    = flags;
                        end
                        OP_MUL: begin
                            alu_func_d = ALU_MUL;
                            w_d        = 1'b1;
                        end
                        OP_MULI: begin
                            alu_func_d = ALU_MUL;
                            w_d        = 1'b1;
                            imm_d      = 1'b1;
                        end
                        OP_DISP: disp_d  = 1'b1;
                        OP_ST:   store_d = 1'b1;
                        OP_BREL, OP_BABS: begin
                            pc_incr_d = 1'b0;
                            br_abs_d  = (opcode == OP_BABS);
                            if (br_go) begin
                                pc_abs_d = (opcode == OP_BABS);
                                pc_rel_d = (opcode == OP_BREL);
                                state_d  = FLUSH;
                            end else begin
                                dec_valid_d = 1'b0;
                                state_d     = BRWAIT;
                            end
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            BRWAIT: begin
                // branch resolution takes priority over the timeout
                if (br_go) begin
                    dec_valid_d = 1'b1;
                    pc_abs_d    = br_abs_q;
                    pc_rel_d    = ~br_abs_q;
                    state_d     = FLUSH;
                end else if (TIMEOUT_EN && (wait_cnt_q == WAIT_LAST)) begin
                    dec_valid_d = 1'b1;
                    pc_incr_d   = 1'b1;
                    state_d     = RUN;
                end else begin
                    wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase

        instr_ready_d = (state_d != BRWAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            flags_q       <= '0;
            br_abs_q      <= 1'b0;
            wait_cnt_q    <= 8'd0;
            alu_func_q    <= '0;
            instr_ready_q <= 1'b0;
            dec_valid_q   <= 1'b0;
            pc_incr_q     <= 1'b0;
            pc_abs_q      <= 1'b0;
            pc_rel_q      <= 1'b0;
            imm_q         <= 1'b0;
            w_q           <= 1'b0;
            store_q       <= 1'b0;
            disp_q        <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            flags_q       <= flags_d;
            br_abs_q      <= br_abs_d;
            wait_cnt_q    <= wait_cnt_d;
            alu_func_q    <= alu_func_d;
            instr_ready_q <= instr_ready_d;
            dec_valid_q   <= dec_valid_d;
            pc_incr_q     <= pc_incr_d;
            pc_abs_q      <= pc_abs_d;
            pc_rel_q      <= pc_rel_d;
            imm_q         <= imm_d;
            w_q           <= w_d;
            store_q       <= store_d;
            disp_q        <= disp_d;
            illegal_q     <= illegal_d;
        end
    end

    assign instr_ready  = instr_ready_q;
    assign dec_valid    = dec_valid_q;
    assign pc_incr      = pc_incr_q;
    assign pc_absbranch = pc_abs_q;
    assign pc_relbranch = pc_rel_q;
    assign ALUfunc      = alu_func_q;
    assign imm          = imm_q;
    assign w            = w_q;
    assign store        = store_q;
    assign disp         = disp_q;
    assign illegal      = illegal_q;
    assign wait_cnt     = wait_cnt_q;

endmodule
